// File: rtl/pc_gen.sv
// Purpose: program-counter generator with BOOT/RUN/HALT control, trap/mret and branch redirect.
// Latency: every request takes effect on the next rising edge; all outputs come straight from flops.
// Backpressure: stall holds the PC in RUN; trap, mret, branch and halt override stall.
module pc_gen #(
  parameter int unsigned                 WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0]       RESET_VECTOR = '0,
  parameter logic [WORD_WIDTH-1:0]       TRAP_VECTOR  = WORD_WIDTH'('h100),
  parameter int unsigned                 INC          = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  branch,
  input  logic [WORD_WIDTH-1:0] branch_target,
  input  logic                  trap,
  input  logic                  mret,
  input  logic                  halt,
  input  logic                  resume,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic                  pc_valid,
  output logic [WORD_WIDTH-1:0] epc_out,
  output logic                  misalign
);

  // INC is a power of two, so alignment is a test of the low log2(INC) bits.
  localparam int unsigned          ALIGN_BITS = $clog2(INC);
  localparam logic [WORD_WIDTH-1:0] INC_W     = WORD_WIDTH'(INC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [WORD_WIDTH-1:0]   pc_next;
  logic [WORD_WIDTH-1:0]   epc_next;
  logic                    misalign_next;
  logic                    target_misaligned;

  assign target_misaligned = |branch_target[ALIGN_BITS-1:0];

  // Next state and next PC/EPC selection; outputs default to holding their value.
  always_comb begin
    state_next    = state;
    pc_next       = pc_out;
    epc_next      = epc_out;
    misalign_next = 1'b0;
    case (state)
      // One dead cycle after reset; every request is ignored here.
      BOOT: state_next = RUN;
      RUN: begin
        if (trap) begin
          pc_next  = TRAP_VECTOR;
          epc_next = pc_out;
        end else if (halt) begin
          // Halt freezes the PC, so it also pre-empts mret/branch/stall.
          state_next = HALT;
        end else if (mret) begin
          pc_next = epc_out;
        end else if (branch) begin
          if (target_misaligned) begin
            // A misaligned target is reported as a trap with the bad target as EPC.
            pc_next       = TRAP_VECTOR;
            epc_next      = branch_target;
            misalign_next = 1'b1;
          end else begin
            pc_next = branch_target;
          end
        end else if (!stall) begin
          // Natural wrap at WORD_WIDTH bits.
          pc_next = pc_out + INC_W;
        end
      end
      HALT: begin
        if (trap) begin
          state_next = RUN;
          pc_next    = TRAP_VECTOR;
          epc_next   = pc_out;
        end else if (resume) begin
          // PC is untouched so the held address is fetched again.
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // State and output registers; pc_valid is registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= BOOT;
      pc_out   <= RESET_VECTOR;
      epc_out  <= '0;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc_out   <= pc_next;
      epc_out  <= epc_next;
      pc_valid <= (state_next == RUN);
      misalign <= misalign_next;
    end
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, giving the width of all address ports and registers.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 'h100, giving the PC value loaded on trap.
REQ-004 The block SHALL have parameter INC, default 4, giving the sequential increment; legal values are powers of two, at least 2.
REQ-005 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port rstn  in  1  asynchronous, active-low reset.
REQ-007 Port stall  in  1  hold the PC this cycle.
REQ-008 Port branch  in  1  redirect to branch_target.
REQ-009 Port branch_target  in  WORD_WIDTH  redirect address.
REQ-010 Port trap  in  1  external exception request.
REQ-011 Port mret  in  1  return from trap to saved EPC.
REQ-012 Port halt  in  1  request to stop fetching.
REQ-013 Port resume  in  1  request to leave HALT.
REQ-014 Port pc_out  out  WORD_WIDTH  current fetch address (registered).
REQ-015 Port pc_valid  out  1  pc_out is a real fetch address this cycle.
REQ-016 Port epc_out  out  WORD_WIDTH  saved exception PC (registered).
REQ-017 Port misalign  out  1  registered one-cycle pulse: last accepted branch target was misaligned.

Function
REQ-018 The block SHALL implement a three-state FSM: BOOT, RUN and HALT.
REQ-019 BOOT SHALL last exactly one cycle after reset release with pc_valid=0, then go to RUN with pc_out=RESET_VECTOR.
REQ-020 In RUN, pc_valid SHALL be 1, and the next PC SHALL be chosen by priority trap > mret > branch > stall > sequential.
REQ-021 trap SHALL load pc_out=TRAP_VECTOR and epc_out=current pc_out on the next edge.
REQ-022 mret SHALL load pc_out=epc_out on the next edge; epc_out SHALL be unchanged.
REQ-023 branch with branch_target mod INC == 0 SHALL load pc_out=branch_target on the next edge.
REQ-024 branch with branch_target mod INC != 0 SHALL behave as a trap (pc_out=TRAP_VECTOR, epc_out=branch_target) and SHALL pulse misalign=1 for one cycle.
REQ-025 stall alone SHALL hold pc_out; sequential update SHALL be pc_out+INC, truncated to WORD_WIDTH, so the all-ones-aligned maximum wraps to 0.
REQ-026 trap, mret and branch SHALL override stall in the same cycle.
REQ-027 halt in RUN (no trap that cycle) SHALL enter HALT on the next edge with pc_out held; trap in the same cycle SHALL win and halt SHALL be ignored.
REQ-028 In HALT, pc_valid SHALL be 0, pc_out SHALL hold, and branch, mret and stall SHALL be ignored.
REQ-029 In HALT, resume SHALL return to RUN on the next edge with pc_out unchanged (refetch of the held address).
REQ-030 In HALT, trap SHALL return to RUN with the REQ-021 action; trap SHALL take priority over resume.
REQ-031 In BOOT, all requests SHALL be ignored.
REQ-032 The block SHALL have no combinational path from any input to any output.

Reset
REQ-033 rstn=0 SHALL asynchronously force state=BOOT, pc_out=RESET_VECTOR, epc_out=0, pc_valid=0 and misalign=0, including mid-operation from any state.

Verification
REQ-034 Reset release, no requests, 4 cycles -> pc_valid 0,1,1,1; pc_out 0,0,4,8.
REQ-035 In RUN at pc 0x10: stall 2 cycles, then branch to 0x40 together with stall -> pc 0x10,0x10,0x40,0x44.
REQ-036 At pc 0x20: branch to 0x42 -> pc_out=0x100, epc_out=0x42, misalign pulses once; then mret -> pc_out=0x42.
REQ-037 At pc 0x30: trap and branch to 0x80 in the same cycle -> pc_out=0x100, epc_out=0x30; mret -> 0x30, then 0x34.
REQ-038 At pc 0x50: halt -> HALT, pc_valid=0, pc held at 0x50 while branch is ignored; resume -> RUN at 0x50, then 0x54; second pass with trap during HALT -> 0x100.
REQ-039 WORD_WIDTH=8, pc 0xFC, sequential -> 0x00; rstn pulsed low mid-HALT -> BOOT, pc_out=RESET_VECTOR immediately.
